// File: rtl/svc_rv_scoreboard.sv
// svc_rv_scoreboard: register-write scoreboard beside the ID stage.
// Keeps one pending-write counter per architectural register (x1..x31).
// Counters count up on issue and down on writeback or squash.
// The ID stall is raised while a source register it reads still has a
// pending write.
// Optional feature macro: SVC_RV_SCOREBOARD_BYPASS_EN. When it is defined,
// a writeback or squash in the current cycle that brings a counter to zero
// releases the stall in that same cycle (regfile write-through).
module svc_rv_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [4:0] issue_rd,
    input  logic       issue_reg_write,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       kill_valid,
    input  logic [4:0] kill_rd,
    output logic       hazard_rs1,
    output logic       hazard_rs2,
    output logic       stall,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt     [1:31];
    logic [CNT_W-1:0] cnt_nxt [1:31];
    logic [1:0]       dec_n   [1:31];
    logic             inc_n   [1:31];
    logic [31:0]      pend;
    logic [31:0]      full;
    logic             issue_fire;
    logic             any_flt;
    logic [CNT_W+1:0] up;
    logic [CNT_W+1:0] dn;
    logic [CNT_W+1:0] diff;

    // Per-register decrement count from this cycle's writeback and squash (x0 excluded).
    always_comb begin
        for (int unsigned r = 1; r < 32; r++) begin
            dec_n[r] = {1'b0, wb_valid   && (wb_rd   == 5'(r))}
                     + {1'b0, kill_valid && (kill_rd == 5'(r))};
        end
    end

    // Pending and full flags per register; bit 0 (x0) is never pending or full.
    always_comb begin
        pend = '0;
        full = '0;
        for (int unsigned r = 1; r < 32; r++) begin
`ifdef SVC_RV_SCOREBOARD_BYPASS_EN
            // A same-cycle retirement that drains the counter releases the source now.
            pend[r] = ((CNT_W+2)'(cnt[r]) > (CNT_W+2)'(dec_n[r]));
`else
            pend[r] = (cnt[r] != '0);
`endif
            full[r] = (cnt[r] == CNT_MAX);
        end
    end

    // Source hazards and the issue handshake; issue_ready never depends on issue_valid.
    always_comb begin
        hazard_rs1  = rs1_used && pend[rs1_id];
        hazard_rs2  = rs2_used && pend[rs2_id];
        stall       = hazard_rs1 || hazard_rs2;
        issue_ready = !stall && !(issue_reg_write && full[issue_rd]);
        issue_fire  = issue_valid && issue_ready;
    end

    // Per-register increment from a fired issue that writes a non-zero rd.
    always_comb begin
        for (int unsigned r = 1; r < 32; r++) begin
            inc_n[r] = issue_fire && issue_reg_write && (issue_rd == 5'(r));
        end
    end

    // Next counter values: clamp at 0 (underflow) and at max (overflow), flagging either.
    always_comb begin
        any_flt = 1'b0;
        up      = '0;
        dn      = '0;
        diff    = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            up   = (CNT_W+2)'(cnt[r]) + (CNT_W+2)'(inc_n[r]);
            dn   = (CNT_W+2)'(dec_n[r]);
            diff = up - dn;
            if (up < dn) begin
                cnt_nxt[r] = '0;
                any_flt    = 1'b1;
            end else if (diff > (CNT_W+2)'(CNT_MAX)) begin
                cnt_nxt[r] = CNT_MAX;
                any_flt    = 1'b1;
            end else begin
                cnt_nxt[r] = diff[CNT_W-1:0];
            end
        end
    end

    // Counter and sticky error registers; reset overrides every same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 1; r < 32; r++) begin
                cnt[r] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            err <= err || any_flt;
        end
    end

endmodule

// File: tb/tb_svc_rv_scoreboard.sv
// Directed self-checking bench for svc_rv_scoreboard (CNT_W = 2).
// Inputs are driven 1 time unit after the rising edge.
// Outputs are checked 1 more unit later, well before the next edge.
module tb_svc_rv_scoreboard;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1_used;
    logic       rs2_used;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] issue_rd;
    logic       issue_reg_write;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       kill_valid;
    logic [4:0] kill_rd;
    logic       hazard_rs1;
    logic       hazard_rs2;
    logic       stall;
    logic       err;

    int vecs;
    int errs;

    svc_rv_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rd(issue_rd), .issue_reg_write(issue_reg_write),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .kill_valid(kill_valid), .kill_rd(kill_rd),
        .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .stall(stall), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land just after the edge, ready to drive.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_id = '0; rs2_id = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_reg_write = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; kill_valid = 1'b0; kill_rd = '0;
    endtask

    task automatic issue_once(input logic [4:0] rd);
        idle();
        issue_valid = 1'b1; issue_rd = rd; issue_reg_write = 1'b1;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        rs1_id = 5'd5; rs1_used = 1'b1;
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", stall); end
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", err); end
        vecs++; if (hazard_rs1 !== 1'b0) begin errs++; $display("FAIL reset_haz1: got %b want 0", hazard_rs1); end
        cyc();
        idle();
    endtask

    task automatic test_issue_hazard();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd10; issue_reg_write = 1'b1;
        #1;
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL issue10_ready: got %b want 1", issue_ready); end
        cyc();
        idle();
        rs1_id = 5'd10; rs1_used = 1'b1;
        #1;
        vecs++; if (hazard_rs1 !== 1'b1) begin errs++; $display("FAIL haz10_rs1: got %b want 1", hazard_rs1); end
        vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL haz10_stall: got %b want 1", stall); end
        vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL haz10_ready: got %b want 0", issue_ready); end
        rs1_used = 1'b0;
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL unused10_stall: got %b want 0", stall); end
        rs2_id = 5'd10; rs2_used = 1'b1;
        #1;
        vecs++; if (hazard_rs2 !== 1'b1) begin errs++; $display("FAIL haz10_rs2: got %b want 1", hazard_rs2); end
        cyc();
        idle();
    endtask

    task automatic test_writeback();
        // cnt[10] == 1 from test_issue_hazard
        idle();
        rs1_id = 5'd10; rs1_used = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd10;
        #1;
`ifdef SVC_RV_SCOREBOARD_BYPASS_EN
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL wb_cycleN_stall: got %b want 0", stall); end
`else
        vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL wb_cycleN_stall: got %b want 1", stall); end
`endif
        cyc();
        wb_valid = 1'b0; wb_rd = '0;
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL wb_cycleN1_stall: got %b want 0", stall); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL wb_err: got %b want 0", err); end
        cyc();
        idle();
    endtask

    task automatic test_overflow();
        issue_once(5'd7);
        issue_once(5'd7);
        issue_once(5'd7);
        // cnt[7] == 3 == max
        issue_valid = 1'b1; issue_rd = 5'd7; issue_reg_write = 1'b1;
        rs1_id = 5'd1; rs2_id = 5'd2; rs1_used = 1'b1; rs2_used = 1'b1;
        #1;
        vecs++; if (issue_ready !== 1'b0) begin errs++; $display("FAIL full7_ready: got %b want 0", issue_ready); end
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL full7_stall: got %b want 0", stall); end
        cyc();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd7;
        cyc();
        // cnt[7] == 2; issue and wb to rd 7 together keep it at 2
        idle();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_reg_write = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd7;
        #1;
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL cnt2_ready: got %b want 1", issue_ready); end
        cyc();
        idle();
        issue_rd = 5'd7; issue_reg_write = 1'b1;
        #1;
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL still2_ready: got %b want 1", issue_ready); end
        idle();
        wb_valid = 1'b1; wb_rd = 5'd7;
        cyc();
        idle();
        rs1_id = 5'd7; rs1_used = 1'b1;
        #1;
        vecs++; if (hazard_rs1 !== 1'b1) begin errs++; $display("FAIL cnt1_haz: got %b want 1", hazard_rs1); end
        idle();
        wb_valid = 1'b1; wb_rd = 5'd7;
        cyc();
        idle();
        rs1_id = 5'd7; rs1_used = 1'b1;
        #1;
        vecs++; if (hazard_rs1 !== 1'b0) begin errs++; $display("FAIL cnt0_haz: got %b want 0", hazard_rs1); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL cnt0_err: got %b want 0", err); end
        idle();
    endtask

    task automatic test_x0_and_err();
        issue_once(5'd0);
        rs1_id = 5'd0; rs2_id = 5'd0; rs1_used = 1'b1; rs2_used = 1'b1;
        issue_rd = 5'd0; issue_reg_write = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd0; kill_valid = 1'b1; kill_rd = 5'd0;
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL x0_stall: got %b want 0", stall); end
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL x0_ready: got %b want 1", issue_ready); end
        cyc();
        idle();
        #1;
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL x0_dec_err: got %b want 0", err); end
        wb_valid = 1'b1; wb_rd = 5'd3;
        cyc();
        idle();
        #1;
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL underflow_err: got %b want 1", err); end
        cyc(); cyc(); cyc();
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL sticky_err: got %b want 1", err); end
    endtask

    task automatic test_dual_dec();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL rst_clears_err: got %b want 0", err); end
        issue_once(5'd4);
        issue_once(5'd4);
        rs1_id = 5'd4; rs1_used = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd4; kill_valid = 1'b1; kill_rd = 5'd4;
        #1;
`ifdef SVC_RV_SCOREBOARD_BYPASS_EN
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL dual_cycleN_stall: got %b want 0", stall); end
`else
        vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL dual_cycleN_stall: got %b want 1", stall); end
`endif
        cyc();
        wb_valid = 1'b0; kill_valid = 1'b0;
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL dual_after_stall: got %b want 0", stall); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL dual_err: got %b want 0", err); end
        idle();
    endtask

    task automatic test_reset_mid();
        issue_once(5'd12);
        wb_valid = 1'b1; wb_rd = 5'd3;
        cyc();
        idle();
        #1;
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL pre_rst_err: got %b want 1", err); end
        rst = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd12; issue_reg_write = 1'b1;
        kill_valid = 1'b1; kill_rd = 5'd9;
        cyc();
        rst = 1'b0;
        idle();
        rs1_id = 5'd12; rs1_used = 1'b1;
        #1;
        vecs++; if (hazard_rs1 !== 1'b0) begin errs++; $display("FAIL rst_mid_haz: got %b want 0", hazard_rs1); end
        vecs++; if (issue_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready: got %b want 1", issue_ready); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL rst_mid_err: got %b want 0", err); end
        idle();
        cyc();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        idle();
        test_reset();
        test_issue_hazard();
        test_writeback();
        test_overflow();
        test_x0_and_err();
        test_dual_dec();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
